// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-limited sharing of one FIFO write port among NREQ producers.
// A grant lasts until req_last, MAX_BURST beats, or the grantee drops valid; fifo_full stalls beats.
module fifo_wr_arbiter #(
    parameter int NREQ = 4,
    parameter int DW = 8,
    parameter int MAX_BURST = 4,
    localparam int IW = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_valid,
    input  logic [NREQ-1:0] req_last,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0] req_ready,
    output logic            fifo_wr,
    output logic [DW-1:0]   fifo_din,
    input  logic            fifo_full,
    output logic            busy,
    output logic [IW-1:0]   grant_id
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state, state_n;
    logic [IW-1:0] grant_n, last_id, last_n, pick, c;
    logic [4:0] beat_cnt, cnt_n;
    logic found, beat, rel;
    // search last_id+1, last_id+2, ... with an explicit wrap so non-power-of-two NREQ works
    always_comb begin
        pick = '0;
        found = 1'b0;
        c = last_id;
        for (int k = 0; k < NREQ; k++) begin
            c = (c == IW'(NREQ - 1)) ? '0 : c + 1'b1;
            if (!found && req_valid[c]) begin
                pick = c;
                found = 1'b1;
            end
        end
    end
    always_comb begin
        busy = state == GRANT;
        beat = busy & ~rst & req_valid[grant_id] & ~fifo_full;
        rel = busy & (~req_valid[grant_id] | (beat & (req_last[grant_id] | beat_cnt == 5'(MAX_BURST - 1))));
        req_ready = beat ? NREQ'(1) << grant_id : '0;
        fifo_wr = beat;
        fifo_din = busy ? req_data[grant_id*DW +: DW] : '0;
        state_n = busy ? (rel ? IDLE : GRANT) : (found ? GRANT : IDLE);
        grant_n = (!busy && found) ? pick : grant_id;
        last_n = rel ? grant_id : last_id;
        cnt_n = busy ? beat_cnt + 5'(beat) : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant_id <= '0;
            last_id <= IW'(NREQ - 1);
            beat_cnt <= '0;
        end else begin
            state <= state_n;
            grant_id <= grant_n;
            last_id <= last_n;
            beat_cnt <= cnt_n;
        end
    end
endmodule
